ddr_axi_responder: RTL and testbench
====================================

# ddr_axi_responder

- Slave-side counterpart to the DDR traffic-generator master.
- Accepts transactions on the combined AXI address channel (`ATYPE` selects read or write).
- Stores write data in an on-chip byte-enabled RAM and returns it on the read channel, giving the UART→DDR datapath a DDR stand-in for simulation and FPGA loopback.
- Produces `B` and `R` responses with correct IDs, `RLAST` and error codes, plus beat counters and a sticky error flag for debug.

## Interface

Parameters
- `BASE_ADDR`, `32'h00000000`: byte address mapped to RAM word 0.
- `MEM_WORDS`, `1024`: RAM depth in 256-bit words; must be a power of 2.
- `DATA_W`, `256`: beat width; fixed, with `ASIZE` = `3'b101`.

Ports
- `axi_clk`, in, 1: single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `DDR_AID_0` in 8, `DDR_AADDR_0` in 32, `DDR_ALEN_0` in 8, `DDR_ASIZE_0` in 3, `DDR_ABURST_0` in 2, `DDR_ALOCK_0` in 2, `DDR_ATYPE_0` in 1 (1 = write), `DDR_AVALID_0` in 1, `DDR_AREADY_0` out 1.
- `DDR_WID_0` in 8, `DDR_WDATA_0` in 256, `DDR_WSTRB_0` in 32, `DDR_WLAST_0` in 1, `DDR_WVALID_0` in 1, `DDR_WREADY_0` out 1.
- `DDR_BID_0` out 8, `DDR_BRESP_0` out 2, `DDR_BVALID_0` out 1, `DDR_BREADY_0` in 1.
- `DDR_RID_0` out 8, `DDR_RDATA_0` out 256, `DDR_RRESP_0` out 2, `DDR_RLAST_0` out 1, `DDR_RVALID_0` out 1, `DDR_RREADY_0` in 1.
- `o_wr_beats`, out, 32: count of accepted W beats.
- `o_rd_beats`, out, 32: count of delivered R beats.
- `o_err`, out, 1: sticky; set by any non-OKAY response.

## Operation

- **FSM states:** `IDLE`, `W_DATA`, `B_RESP`, `R_FETCH`, `R_DATA`.
- **Transaction model:** one outstanding transaction at a time; no interleaving.
- **`IDLE`:**
  - `AREADY` = 1.
  - On `AVALID & AREADY`, latch `AID`, the word index, the beat counter (= `ALEN`), the burst type and the error status.
  - Next state: `W_DATA` if `ATYPE` = 1, otherwise `R_FETCH`.
- **Address decode:**
  - Word index = (`AADDR` − `BASE_ADDR`) >> 5.
  - Out of range when `AADDR` < `BASE_ADDR`, or when index + `ALEN` ≥ `MEM_WORDS` for INCR bursts (index alone for FIXED) → DECERR (`2'b11`).
  - `ASIZE` ≠ `3'b101`, or `ABURST` ∉ {`00` FIXED, `01` INCR} → SLVERR (`2'b10`).
  - DECERR takes priority over SLVERR.
- **`W_DATA`:**
  - `WREADY` = 1.
  - Each `WVALID & WREADY` beat writes the RAM with byte enables `WSTRB`, unless the transaction is erroneous (then the write is dropped).
  - INCR increments the index by 1 per beat; FIXED holds it.
  - The beat counter decrements; the burst ends on the beat where the counter = 0, regardless of `WLAST`.
  - `WLAST` asserted on a non-final beat, or deasserted on the final beat → SLVERR for that transaction. `WID` is ignored.
- **`B_RESP`:**
  - `BVALID` = 1, `BID` = latched ID, `BRESP` = accumulated code.
  - Held stable until `BREADY`, then `IDLE`.
- **`R_FETCH`:**
  - One cycle: drive the RAM read address. Nothing is read for erroneous transactions.
  - Next state: `R_DATA`.
- **`R_DATA`:**
  - `RVALID` = 1; `RDATA` = RAM output (zero if erroneous).
  - `RID` = latched ID, `RRESP` = code, `RLAST` = (counter = 0).
  - All R outputs held stable while `RREADY` = 0.
  - On handshake: if last → `IDLE`, else advance the index and return to `R_FETCH`.
- **`ALOCK`:** ignored.
- **Counters:** 32-bit, wrap modulo 2^32.
- **`o_err`:** set on issue of any SLVERR/DECERR B or R beat; cleared only by reset.

## Timing

- **Reset values** (all outputs): `AREADY`/`WREADY`/`BVALID`/`RVALID`/`RLAST` = 0, all IDs/data/resp = 0, counters = 0, `o_err` = 0, state = `IDLE`. `AREADY` rises the first cycle after reset release.
- **Reset mid-transaction:** the FSM aborts to `IDLE` and no response is issued. RAM contents are retained, not cleared.
- **Write:** address handshake at cycle N → `WREADY` at N+1. With continuous `WVALID`, the last beat lands at N+1+`ALEN`. `BVALID` rises the cycle after the last beat.
- **Read:** address handshake at N → first `RVALID` at N+2. Sustained rate is one beat per 2 cycles (fetch + data). Each beat: `RVALID` falls the cycle after its handshake.
- **Ready gating:** `AREADY` = 0 in every state except `IDLE`. `WREADY` = 0 outside `W_DATA`.
- **RAM:** synchronous, read latency 1. Read-during-write cannot occur (single transaction at a time).
- **Valid/ready rule:** valid is never dropped before its handshake; ready does not depend combinationally on valid.

## Structure

- **Package `ddr_axi_pkg`:**
  - response codes `RESP_OKAY`/`EXOKAY`/`SLVERR`/`DECERR`;
  - burst codes `BURST_FIXED`/`INCR`;
  - `ASIZE_32B` = `3'b101`;
  - state encoding shared with the master's debug decode.
- **Sub-module `ddr_mem_sdp`:**
  - simple-dual-port RAM, `MEM_WORDS` × 256;
  - 32 byte write enables;
  - registered read.

## Test plan

- **Full write then read:** write INCR `AADDR` = `0x40`, `ALEN` = 3, data 0xA0..0xA3, `WSTRB` all ones → `BRESP` = 00, `BID` = `AID`. Read the same address → 4 beats 0xA0..0xA3, `RLAST` only on the 4th beat, `o_wr_beats` = 4, `o_rd_beats` = 4.
- **Partial strobe:** write word 5 with 0xFF.., then write 0x00.. with `WSTRB` = `0x0000000F` → readback has bytes 0–3 = 00 and the rest FF.
- **Backpressure:** toggle `BREADY`/`RREADY` low for 3 cycles mid-burst → `BVALID`/`RVALID` and their payloads stay stable; no beat lost or duplicated.
- **Address errors:** `AADDR` = `BASE_ADDR` + `MEM_WORDS`×32 → DECERR on B (write) or on every R beat (read), `RDATA` = 0, RAM unchanged, `o_err` = 1. `ASIZE` = `3'b100` → SLVERR.
- **Early `WLAST`:** `ALEN` = 2 with `WLAST` on beat 1 → 3 beats still accepted, `BRESP` = 10.
- **Reset mid-read:** pulse `rst` after the 2nd of 8 beats → all outputs return to reset values and `AREADY` = 1 next cycle. A new read of the same address returns the data written earlier.

Source files
------------

// File: rtl/ddr_axi_pkg.sv
// Shared constants for the DDR AXI responder and the traffic-generator master:
// response codes, burst types, beat size and the FSM encoding used by debug decode.
package ddr_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [2:0] ASIZE_32B = 3'b101;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_W_DATA  = 3'd1;
    localparam logic [2:0] ST_B_RESP  = 3'd2;
    localparam logic [2:0] ST_R_FETCH = 3'd3;
    localparam logic [2:0] ST_R_DATA  = 3'd4;

    // Keeps the most severe code seen so far; DECERR outranks SLVERR outranks OKAY.
    function automatic logic [1:0] merge_resp(input logic [1:0] cur, input logic [1:0] nw);
        if (nw == RESP_EXOKAY) return cur;
        return (nw > cur) ? nw : cur;
    endfunction

endpackage

// File: rtl/ddr_axi_responder_if.sv
// Combined-address-channel AXI bus between the DDR traffic generator and its responder.
interface ddr_axi_responder_if;

    logic [7:0]   DDR_AID_0;
    logic [31:0]  DDR_AADDR_0;
    logic [7:0]   DDR_ALEN_0;
    logic [2:0]   DDR_ASIZE_0;
    logic [1:0]   DDR_ABURST_0;
    logic [1:0]   DDR_ALOCK_0;
    logic         DDR_ATYPE_0;
    logic         DDR_AVALID_0;
    logic         DDR_AREADY_0;

    logic [7:0]   DDR_WID_0;
    logic [255:0] DDR_WDATA_0;
    logic [31:0]  DDR_WSTRB_0;
    logic         DDR_WLAST_0;
    logic         DDR_WVALID_0;
    logic         DDR_WREADY_0;

    logic [7:0]   DDR_BID_0;
    logic [1:0]   DDR_BRESP_0;
    logic         DDR_BVALID_0;
    logic         DDR_BREADY_0;

    logic [7:0]   DDR_RID_0;
    logic [255:0] DDR_RDATA_0;
    logic [1:0]   DDR_RRESP_0;
    logic         DDR_RLAST_0;
    logic         DDR_RVALID_0;
    logic         DDR_RREADY_0;

    modport master (
        output DDR_AID_0, DDR_AADDR_0, DDR_ALEN_0, DDR_ASIZE_0, DDR_ABURST_0,
               DDR_ALOCK_0, DDR_ATYPE_0, DDR_AVALID_0,
               DDR_WID_0, DDR_WDATA_0, DDR_WSTRB_0, DDR_WLAST_0, DDR_WVALID_0,
               DDR_BREADY_0, DDR_RREADY_0,
        input  DDR_AREADY_0, DDR_WREADY_0,
               DDR_BID_0, DDR_BRESP_0, DDR_BVALID_0,
               DDR_RID_0, DDR_RDATA_0, DDR_RRESP_0, DDR_RLAST_0, DDR_RVALID_0
    );

    modport slave (
        input  DDR_AID_0, DDR_AADDR_0, DDR_ALEN_0, DDR_ASIZE_0, DDR_ABURST_0,
               DDR_ALOCK_0, DDR_ATYPE_0, DDR_AVALID_0,
               DDR_WID_0, DDR_WDATA_0, DDR_WSTRB_0, DDR_WLAST_0, DDR_WVALID_0,
               DDR_BREADY_0, DDR_RREADY_0,
        output DDR_AREADY_0, DDR_WREADY_0,
               DDR_BID_0, DDR_BRESP_0, DDR_BVALID_0,
               DDR_RID_0, DDR_RDATA_0, DDR_RRESP_0, DDR_RLAST_0, DDR_RVALID_0
    );

endinterface

// File: rtl/ddr_mem_sdp.sv
// Simple-dual-port RAM with per-byte write enables and a registered read port.
// The array itself is never reset so contents survive a responder reset.
module ddr_mem_sdp #(
    parameter int WORDS  = 1024,
    parameter int DATA_W = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [$clog2(WORDS)-1:0]   waddr,
    input  logic [DATA_W/8-1:0]        wstrb,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       re,
    input  logic [$clog2(WORDS)-1:0]   raddr,
    output logic [DATA_W-1:0]          rdata
);

    localparam int BYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/ddr_axi_responder.sv
// AXI slave standing in for DDR: one transaction at a time, writes land in an
// on-chip RAM and reads return them, with AXI-style error responses and debug counters.
module ddr_axi_responder
    import ddr_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MEM_WORDS = 1024,
    parameter int          DATA_W    = 256
) (
    input  logic               axi_clk,
    input  logic               rst,
    ddr_axi_responder_if.slave ddr,
    output logic [31:0]        o_wr_beats,
    output logic [31:0]        o_rd_beats,
    output logic               o_err
);

    localparam int         AW    = $clog2(MEM_WORDS);
    localparam logic [27:0] DEPTH = 28'(MEM_WORDS);

    logic [2:0]        st, st_next;
    logic [7:0]        id_q, cnt_q;
    logic [AW-1:0]     idx_q;
    logic [1:0]        burst_q, resp_q;
    logic              addr_err_q;
    logic              aready_q, wready_q, bvalid_q, rvalid_q;
    logic [DATA_W-1:0] mem_rdata;

    logic [31:0] addr_off;
    logic [27:0] word_idx, end_idx;
    logic        dec_err, slv_err;
    logic [1:0]  a_resp;
    logic        a_hs, w_hs, b_hs, r_hs, last_beat, wlast_bad;
    logic        unused_ok;

    // Address decode; an out-of-range FIXED burst only cares about its single word.
    always_comb begin
        addr_off = ddr.DDR_AADDR_0 - BASE_ADDR;
        word_idx = {1'b0, addr_off[31:5]};
        end_idx  = word_idx + {20'd0, ddr.DDR_ALEN_0};
        dec_err  = (ddr.DDR_AADDR_0 < BASE_ADDR) ||
                   ((ddr.DDR_ABURST_0 == BURST_FIXED) ? (word_idx >= DEPTH) : (end_idx >= DEPTH));
        slv_err  = (ddr.DDR_ASIZE_0 != ASIZE_32B) || ddr.DDR_ABURST_0[1];
        a_resp   = dec_err ? RESP_DECERR : (slv_err ? RESP_SLVERR : RESP_OKAY);
    end

    assign a_hs      = aready_q & ddr.DDR_AVALID_0;
    assign w_hs      = wready_q & ddr.DDR_WVALID_0;
    assign b_hs      = bvalid_q & ddr.DDR_BREADY_0;
    assign r_hs      = rvalid_q & ddr.DDR_RREADY_0;
    assign last_beat = (cnt_q == 8'd0);
    assign wlast_bad = (ddr.DDR_WLAST_0 != last_beat);
    assign unused_ok = ^{ddr.DDR_ALOCK_0, ddr.DDR_WID_0, addr_off[4:0]};

    always_comb begin
        st_next = st;
        case (st)
            ST_IDLE:    if (a_hs) st_next = ddr.DDR_ATYPE_0 ? ST_W_DATA : ST_R_FETCH;
            ST_W_DATA:  if (w_hs && last_beat) st_next = ST_B_RESP;
            ST_B_RESP:  if (b_hs) st_next = ST_IDLE;
            ST_R_FETCH: st_next = ST_R_DATA;
            ST_R_DATA:  if (r_hs) st_next = last_beat ? ST_IDLE : ST_R_FETCH;
            default:    st_next = ST_IDLE;
        endcase
    end

    // Ready/valid flags are registered from the next state so none depend on the peer's valid.
    always_ff @(posedge axi_clk or posedge rst) begin
        if (rst) begin
            st         <= ST_IDLE;
            aready_q   <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            id_q       <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            burst_q    <= '0;
            resp_q     <= RESP_OKAY;
            addr_err_q <= 1'b0;
            o_wr_beats <= '0;
            o_rd_beats <= '0;
            o_err      <= 1'b0;
        end else begin
            st       <= st_next;
            aready_q <= (st_next == ST_IDLE);
            wready_q <= (st_next == ST_W_DATA);
            bvalid_q <= (st_next == ST_B_RESP);
            rvalid_q <= (st_next == ST_R_DATA);

            if (a_hs) begin
                id_q       <= ddr.DDR_AID_0;
                cnt_q      <= ddr.DDR_ALEN_0;
                idx_q      <= word_idx[AW-1:0];
                burst_q    <= ddr.DDR_ABURST_0;
                resp_q     <= a_resp;
                addr_err_q <= (a_resp != RESP_OKAY);
            end

            if (w_hs) begin
                o_wr_beats <= o_wr_beats + 32'd1;
                if (wlast_bad) resp_q <= merge_resp(resp_q, RESP_SLVERR);
                if (!last_beat) begin
                    cnt_q <= cnt_q - 8'd1;
                    idx_q <= idx_q + AW'(burst_q == BURST_INCR);
                end
            end

            if (r_hs) begin
                o_rd_beats <= o_rd_beats + 32'd1;
                if (!last_beat) begin
                    cnt_q <= cnt_q - 8'd1;
                    idx_q <= idx_q + AW'(burst_q == BURST_INCR);
                end
            end

            if (((st == ST_B_RESP) || (st == ST_R_DATA)) && (resp_q != RESP_OKAY)) o_err <= 1'b1;
        end
    end

    ddr_mem_sdp #(.WORDS(MEM_WORDS), .DATA_W(DATA_W)) u_mem (
        .clk   (axi_clk),
        .rst   (rst),
        .we    (w_hs && !addr_err_q),
        .waddr (idx_q),
        .wstrb (ddr.DDR_WSTRB_0),
        .wdata (ddr.DDR_WDATA_0),
        .re    ((st == ST_R_FETCH) && !addr_err_q),
        .raddr (idx_q),
        .rdata (mem_rdata)
    );

    assign ddr.DDR_AREADY_0 = aready_q;
    assign ddr.DDR_WREADY_0 = wready_q;
    assign ddr.DDR_BVALID_0 = bvalid_q;
    assign ddr.DDR_BID_0    = id_q;
    assign ddr.DDR_BRESP_0  = resp_q;
    assign ddr.DDR_RVALID_0 = rvalid_q;
    assign ddr.DDR_RID_0    = id_q;
    assign ddr.DDR_RRESP_0  = resp_q;
    assign ddr.DDR_RLAST_0  = rvalid_q && last_beat;
    assign ddr.DDR_RDATA_0  = (rvalid_q && !addr_err_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_ddr_axi_responder.sv
// Directed bench for ddr_axi_responder: write/read bursts, strobes, backpressure,
// address/size errors, early WLAST and reset in the middle of a read.
module tb_ddr_axi_responder;
    import ddr_axi_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_1000;

    typedef logic [255:0] beat_t;

    logic        axi_clk = 1'b0;
    logic        rst     = 1'b1;
    logic [31:0] wr_beats, rd_beats;
    logic        err;

    int errors = 0;
    int checks = 0;
    int exp_wr = 0;
    int exp_rd = 0;

    beat_t wbuf [16];
    beat_t rexp [16];

    ddr_axi_responder_if bus ();

    ddr_axi_responder #(.BASE_ADDR(BASE), .MEM_WORDS(1024), .DATA_W(256)) dut (
        .axi_clk    (axi_clk),
        .rst        (rst),
        .ddr        (bus),
        .o_wr_beats (wr_beats),
        .o_rd_beats (rd_beats),
        .o_err      (err)
    );

    always #5 axi_clk = ~axi_clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input beat_t got, input beat_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge axi_clk);
        #1;
    endtask

    function automatic beat_t fill(input logic [7:0] b);
        return {32{b}};
    endfunction

    // Presents one address beat and returns just after its handshake edge.
    task automatic applyStimulus(input logic atype, input logic [7:0] id, input logic [31:0] addr,
                                 input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        int n;
        bus.DDR_AID_0    = id;
        bus.DDR_AADDR_0  = addr;
        bus.DDR_ALEN_0   = len;
        bus.DDR_ASIZE_0  = size;
        bus.DDR_ABURST_0 = burst;
        bus.DDR_ATYPE_0  = atype;
        bus.DDR_AVALID_0 = 1'b1;
        n = 0;
        while (!bus.DDR_AREADY_0 && n < 20) begin step(); n++; end
        if (!bus.DDR_AREADY_0) checkOutput("aready_timeout", 0, 1);
        step();
        bus.DDR_AVALID_0 = 1'b0;
    endtask

    task automatic writeBurst(input int len, input logic [31:0] strb, input int early_last);
        int n;
        checkOutput("wready_first", beat_t'(bus.DDR_WREADY_0), 1);
        for (int i = 0; i <= len; i++) begin
            bus.DDR_WDATA_0  = wbuf[i];
            bus.DDR_WSTRB_0  = strb;
            bus.DDR_WLAST_0  = (early_last >= 0) ? (i == early_last) : (i == len);
            bus.DDR_WVALID_0 = 1'b1;
            n = 0;
            while (!bus.DDR_WREADY_0 && n < 20) begin step(); n++; end
            if (!bus.DDR_WREADY_0) checkOutput("wready_timeout", 0, 1);
            step();
            exp_wr++;
        end
        bus.DDR_WVALID_0 = 1'b0;
        bus.DDR_WLAST_0  = 1'b0;
        checkOutput("wready_after", beat_t'(bus.DDR_WREADY_0), 0);
    endtask

    task automatic waitResp(input logic [7:0] id, input logic [1:0] resp, input int hold);
        int n;
        n = 0;
        while (!bus.DDR_BVALID_0 && n < 20) begin step(); n++; end
        checkOutput("bvalid", beat_t'(bus.DDR_BVALID_0), 1);
        checkOutput("bid", beat_t'(bus.DDR_BID_0), beat_t'(id));
        checkOutput("bresp", beat_t'(bus.DDR_BRESP_0), beat_t'(resp));
        for (int k = 0; k < hold; k++) begin
            step();
            checkOutput("bvalid_hold", beat_t'(bus.DDR_BVALID_0), 1);
            checkOutput("bresp_hold", beat_t'({bus.DDR_BID_0, bus.DDR_BRESP_0}), beat_t'({id, resp}));
        end
        bus.DDR_BREADY_0 = 1'b1;
        step();
        bus.DDR_BREADY_0 = 1'b0;
        checkOutput("bvalid_drop", beat_t'(bus.DDR_BVALID_0), 0);
    endtask

    // Consumes up to nb beats of a len+1 beat burst, stalling RREADY on hold_beat.
    task automatic readBurst(input int len, input logic [7:0] id, input logic [1:0] resp,
                             input int hold_beat, input int nb);
        int n;
        for (int i = 0; i <= len && i < nb; i++) begin
            n = 0;
            while (!bus.DDR_RVALID_0 && n < 20) begin step(); n++; end
            checkOutput("r_latency", beat_t'(n), 1);
            checkOutput("rdata", bus.DDR_RDATA_0, rexp[i]);
            checkOutput("rresp", beat_t'(bus.DDR_RRESP_0), beat_t'(resp));
            checkOutput("rid", beat_t'(bus.DDR_RID_0), beat_t'(id));
            checkOutput("rlast", beat_t'(bus.DDR_RLAST_0), beat_t'(i == len));
            if (i == hold_beat) begin
                for (int k = 0; k < 3; k++) begin
                    step();
                    checkOutput("rvalid_hold", beat_t'(bus.DDR_RVALID_0), 1);
                    checkOutput("rdata_hold", bus.DDR_RDATA_0, rexp[i]);
                    checkOutput("rlast_hold", beat_t'(bus.DDR_RLAST_0), beat_t'(i == len));
                end
            end
            bus.DDR_RREADY_0 = 1'b1;
            step();
            bus.DDR_RREADY_0 = 1'b0;
            exp_rd++;
            checkOutput("rvalid_drop", beat_t'(bus.DDR_RVALID_0), 0);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_ready"}, beat_t'({bus.DDR_AREADY_0, bus.DDR_WREADY_0}), 0);
        checkOutput({tag, "_valid"}, beat_t'({bus.DDR_BVALID_0, bus.DDR_RVALID_0, bus.DDR_RLAST_0}), 0);
        checkOutput({tag, "_ids"}, beat_t'({bus.DDR_BID_0, bus.DDR_RID_0, bus.DDR_BRESP_0, bus.DDR_RRESP_0}), 0);
        checkOutput({tag, "_rdata"}, bus.DDR_RDATA_0, 0);
        checkOutput({tag, "_counters"}, beat_t'({wr_beats, rd_beats, err}), 0);
    endtask

    initial begin
        bus.DDR_AID_0 = '0;   bus.DDR_AADDR_0 = '0;  bus.DDR_ALEN_0 = '0;
        bus.DDR_ASIZE_0 = '0; bus.DDR_ABURST_0 = '0; bus.DDR_ALOCK_0 = '0;
        bus.DDR_ATYPE_0 = 1'b0; bus.DDR_AVALID_0 = 1'b0;
        bus.DDR_WID_0 = '0;   bus.DDR_WDATA_0 = '0;  bus.DDR_WSTRB_0 = '0;
        bus.DDR_WLAST_0 = 1'b0; bus.DDR_WVALID_0 = 1'b0;
        bus.DDR_BREADY_0 = 1'b0; bus.DDR_RREADY_0 = 1'b0;

        step();
        step();
        checkIdleOutputs("reset");
        rst = 1'b0;
        checkOutput("aready_pre", beat_t'(bus.DDR_AREADY_0), 0);
        step();
        checkOutput("aready_up", beat_t'(bus.DDR_AREADY_0), 1);

        $display("[TB] full write then read");
        for (int i = 0; i < 4; i++) wbuf[i] = fill(8'hA0 + 8'(i));
        applyStimulus(1'b1, 8'h11, BASE + 32'h40, 8'd3, ASIZE_32B, BURST_INCR);
        writeBurst(3, '1, -1);
        waitResp(8'h11, RESP_OKAY, 3);
        checkOutput("wr_beats_1", beat_t'(wr_beats), beat_t'(exp_wr));
        for (int i = 0; i < 4; i++) rexp[i] = fill(8'hA0 + 8'(i));
        applyStimulus(1'b0, 8'h22, BASE + 32'h40, 8'd3, ASIZE_32B, BURST_INCR);
        readBurst(3, 8'h22, RESP_OKAY, 1, 4);
        checkOutput("rd_beats_1", beat_t'(rd_beats), 4);
        checkOutput("err_clean", beat_t'(err), 0);

        $display("[TB] partial strobe");
        wbuf[0] = fill(8'hFF);
        applyStimulus(1'b1, 8'h03, BASE + 32'hA0, 8'd0, ASIZE_32B, BURST_INCR);
        writeBurst(0, '1, -1);
        waitResp(8'h03, RESP_OKAY, 0);
        wbuf[0] = '0;
        applyStimulus(1'b1, 8'h04, BASE + 32'hA0, 8'd0, ASIZE_32B, BURST_INCR);
        writeBurst(0, 32'h0000_000F, -1);
        waitResp(8'h04, RESP_OKAY, 0);
        rexp[0] = {{28{8'hFF}}, 32'h0};
        rexp[1] = rexp[0];
        applyStimulus(1'b0, 8'h05, BASE + 32'hA0, 8'd1, ASIZE_32B, BURST_FIXED);
        readBurst(1, 8'h05, RESP_OKAY, -1, 2);

        $display("[TB] address and size errors");
        wbuf[0] = fill(8'h77);
        applyStimulus(1'b1, 8'h06, BASE, 8'd0, ASIZE_32B, BURST_INCR);
        writeBurst(0, '1, -1);
        waitResp(8'h06, RESP_OKAY, 0);
        wbuf[0] = fill(8'h55);
        applyStimulus(1'b1, 8'h44, BASE + 32'h8000, 8'd0, ASIZE_32B, BURST_INCR);
        writeBurst(0, '1, -1);
        waitResp(8'h44, RESP_DECERR, 0);
        checkOutput("err_sticky", beat_t'(err), 1);
        rexp[0] = fill(8'h77);
        applyStimulus(1'b0, 8'h07, BASE, 8'd0, ASIZE_32B, BURST_INCR);
        readBurst(0, 8'h07, RESP_OKAY, -1, 1);
        rexp[0] = '0;
        rexp[1] = '0;
        applyStimulus(1'b0, 8'h45, BASE + 32'h8000, 8'd1, ASIZE_32B, BURST_INCR);
        readBurst(1, 8'h45, RESP_DECERR, -1, 2);
        applyStimulus(1'b0, 8'h46, BASE - 32'h20, 8'd0, ASIZE_32B, BURST_INCR);
        readBurst(0, 8'h46, RESP_DECERR, -1, 1);
        wbuf[0] = fill(8'h99);
        applyStimulus(1'b1, 8'h47, BASE, 8'd0, 3'b100, BURST_INCR);
        writeBurst(0, '1, -1);
        waitResp(8'h47, RESP_SLVERR, 0);
        applyStimulus(1'b0, 8'h48, BASE, 8'd0, ASIZE_32B, 2'b10);
        readBurst(0, 8'h48, RESP_SLVERR, -1, 1);
        rexp[0] = fill(8'h77);
        applyStimulus(1'b0, 8'h49, BASE, 8'd0, ASIZE_32B, BURST_INCR);
        readBurst(0, 8'h49, RESP_OKAY, -1, 1);

        $display("[TB] top-of-memory boundary");
        for (int i = 0; i < 4; i++) wbuf[i] = fill(8'hE0 + 8'(i));
        applyStimulus(1'b1, 8'h4A, BASE + 32'h7F80, 8'd3, ASIZE_32B, BURST_INCR);
        writeBurst(3, '1, -1);
        waitResp(8'h4A, RESP_OKAY, 0);
        for (int i = 0; i < 5; i++) rexp[i] = '0;
        applyStimulus(1'b0, 8'h4B, BASE + 32'h7F80, 8'd4, ASIZE_32B, BURST_INCR);
        readBurst(4, 8'h4B, RESP_DECERR, -1, 5);

        $display("[TB] early WLAST");
        for (int i = 0; i < 3; i++) wbuf[i] = fill(8'hC0 + 8'(i));
        applyStimulus(1'b1, 8'h50, BASE + 32'h100, 8'd2, ASIZE_32B, BURST_INCR);
        writeBurst(2, '1, 1);
        waitResp(8'h50, RESP_SLVERR, 0);
        checkOutput("wr_beats_2", beat_t'(wr_beats), beat_t'(exp_wr));
        checkOutput("rd_beats_2", beat_t'(rd_beats), beat_t'(exp_rd));

        $display("[TB] reset mid-read");
        for (int i = 0; i < 8; i++) wbuf[i] = fill(8'h30 + 8'(i));
        applyStimulus(1'b1, 8'h5F, BASE + 32'h200, 8'd7, ASIZE_32B, BURST_INCR);
        writeBurst(7, '1, -1);
        waitResp(8'h5F, RESP_OKAY, 0);
        for (int i = 0; i < 8; i++) rexp[i] = fill(8'h30 + 8'(i));
        applyStimulus(1'b0, 8'h60, BASE + 32'h200, 8'd7, ASIZE_32B, BURST_INCR);
        readBurst(7, 8'h60, RESP_OKAY, -1, 2);
        rst = 1'b1;
        #1;
        checkIdleOutputs("midreset");
        @(posedge axi_clk);
        #1;
        rst = 1'b0;
        exp_wr = 0;
        exp_rd = 0;
        step();
        checkOutput("aready_after_reset", beat_t'(bus.DDR_AREADY_0), 1);
        applyStimulus(1'b0, 8'h61, BASE + 32'h200, 8'd7, ASIZE_32B, BURST_INCR);
        readBurst(7, 8'h61, RESP_OKAY, 4, 8);
        checkOutput("rd_beats_3", beat_t'(rd_beats), beat_t'(exp_rd));
        checkOutput("wr_beats_3", beat_t'(wr_beats), beat_t'(exp_wr));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
